// File: rtl/dat_write_buf.sv
// Narrow-to-wide write packer: collects lane writes into one wide word with a
// per-lane written mask, then holds it for a valid/ready handshake downstream.
module dat_write_buf #(
  parameter  int WIDTH_DATA_IN  = 8,
  parameter  int WIDTH_DATA_OUT = 32,
  localparam int LANES          = WIDTH_DATA_OUT / WIDTH_DATA_IN,
  localparam int WIDTH_ADDR     = $clog2(LANES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      iVld,
  output logic                      oRdy,
  input  logic [WIDTH_ADDR-1:0]     iAddr,
  input  logic [WIDTH_DATA_IN-1:0]  iDat,
  input  logic                      iFlush,
  output logic                      oVld,
  input  logic                      iRdy,
  output logic [WIDTH_DATA_OUT-1:0] oDat,
  output logic [LANES-1:0]          oMask
);

  if ((WIDTH_DATA_OUT % WIDTH_DATA_IN) != 0 || LANES < 2) begin : g_param_check
    $error("WIDTH_DATA_OUT must be an integer multiple (>=2) of WIDTH_DATA_IN");
  end

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [WIDTH_DATA_OUT-1:0] dat_q,   dat_d;
  logic [LANES-1:0]          mask_q,  mask_d;
  logic                      wr_acc;

  assign wr_acc = iVld && (state_q == FILL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      dat_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    mask_d  = mask_q;
    unique case (state_q)
      FILL: begin
        // Out-of-range lane indices match no k and are silently dropped.
        for (int k = 0; k < LANES; k++) begin
          if (wr_acc && (iAddr == k[WIDTH_ADDR-1:0])) begin
            dat_d[k*WIDTH_DATA_IN +: WIDTH_DATA_IN] = iDat;
            mask_d[k]                               = 1'b1;
          end
        end
        if (&mask_d) begin
          state_d = EMIT;
        end else if (iFlush && (|mask_d)) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (iRdy) begin
          state_d = FILL;
          dat_d   = '0;
          mask_d  = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign oVld  = (state_q == EMIT);
  assign oRdy  = (state_q == FILL);
  assign oDat  = dat_q;
  assign oMask = mask_q;

endmodule

// File: tb/tb_dat_write_buf.sv
// Bench for dat_write_buf at default widths: per-cycle vector table, scoreboard
// of emitted words, and hand sequences for backpressure and async reset.
module tb_dat_write_buf;

  logic        clk;
  logic        rst_n;
  logic        iVld;
  logic        oRdy;
  logic [1:0]  iAddr;
  logic [7:0]  iDat;
  logic        iFlush;
  logic        oVld;
  logic        iRdy;
  logic [31:0] oDat;
  logic [3:0]  oMask;

  dat_write_buf #(.WIDTH_DATA_IN(8), .WIDTH_DATA_OUT(32)) dut (
    .clk(clk), .rst_n(rst_n), .iVld(iVld), .oRdy(oRdy), .iAddr(iAddr),
    .iDat(iDat), .iFlush(iFlush), .oVld(oVld), .iRdy(iRdy), .oDat(oDat),
    .oMask(oMask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [1:0]  addr;
    logic [7:0]  dat;
    logic        flush;
    logic        rdy;
    logic        push;
    logic [31:0] pdat;
    logic [3:0]  pmask;
    logic        evld;
    logic        erdy;
    logic [31:0] edat;
    logic [3:0]  emask;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  m;
  } word_t;

  vec_t  vecs[16];
  word_t sb_q[$];
  int    n_total = 0;
  int    n_pass  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endfunction

  function automatic void chk_out(string name, logic v, logic r, logic [31:0] d, logic [3:0] m);
    chk({name, ".oVld"},  {31'b0, oVld},  {31'b0, v});
    chk({name, ".oRdy"},  {31'b0, oRdy},  {31'b0, r});
    chk({name, ".oDat"},  oDat,           d);
    chk({name, ".oMask"}, {28'b0, oMask}, {28'b0, m});
  endfunction

  task automatic drive(logic v, logic [1:0] a, logic [7:0] d, logic f, logic r);
    iVld = v; iAddr = a; iDat = d; iFlush = f; iRdy = r;
  endtask

  task automatic cyc(logic v, logic [1:0] a, logic [7:0] d, logic f, logic r);
    drive(v, a, d, f, r);
    @(posedge clk);
    #1;
  endtask

  // Word handshake happens at the next rising edge when both are high here.
  always @(negedge clk) begin
    if (rst_n && oVld && iRdy) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: got 0x%08h/%b expected no word", oDat, oMask);
      end else begin
        word_t w;
        w = sb_q.pop_front();
        chk("sb_dat",  oDat,           w.d);
        chk("sb_mask", {28'b0, oMask}, {28'b0, w.m});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          vld a  dat    fl rdy push pdat          pmask    evld erdy edat          emask
    vecs[0]  = '{1, 0, 8'h11, 0, 1, 0, 32'h0,        4'b0000, 0, 1, 32'h00000011, 4'b0001};
    vecs[1]  = '{1, 1, 8'h22, 0, 1, 0, 32'h0,        4'b0000, 0, 1, 32'h00002211, 4'b0011};
    vecs[2]  = '{1, 2, 8'h33, 0, 1, 0, 32'h0,        4'b0000, 0, 1, 32'h00332211, 4'b0111};
    vecs[3]  = '{1, 3, 8'h44, 0, 1, 1, 32'h44332211, 4'b1111, 1, 0, 32'h44332211, 4'b1111};
    vecs[4]  = '{0, 0, 8'h00, 0, 1, 0, 32'h0,        4'b0000, 0, 1, 32'h00000000, 4'b0000};
    vecs[5]  = '{1, 2, 8'hAB, 0, 1, 0, 32'h0,        4'b0000, 0, 1, 32'h00AB0000, 4'b0100};
    vecs[6]  = '{0, 0, 8'h00, 1, 1, 1, 32'h00AB0000, 4'b0100, 1, 0, 32'h00AB0000, 4'b0100};
    vecs[7]  = '{0, 0, 8'h00, 0, 1, 0, 32'h0,        4'b0000, 0, 1, 32'h00000000, 4'b0000};
    vecs[8]  = '{1, 1, 8'h55, 1, 1, 1, 32'h00005500, 4'b0010, 1, 0, 32'h00005500, 4'b0010};
    vecs[9]  = '{0, 0, 8'h00, 0, 1, 0, 32'h0,        4'b0000, 0, 1, 32'h00000000, 4'b0000};
    vecs[10] = '{0, 0, 8'h00, 1, 1, 0, 32'h0,        4'b0000, 0, 1, 32'h00000000, 4'b0000};
    vecs[11] = '{1, 0, 8'h01, 0, 1, 0, 32'h0,        4'b0000, 0, 1, 32'h00000001, 4'b0001};
    vecs[12] = '{1, 0, 8'h02, 0, 1, 0, 32'h0,        4'b0000, 0, 1, 32'h00000002, 4'b0001};
    vecs[13] = '{0, 0, 8'h00, 1, 0, 1, 32'h00000002, 4'b0001, 1, 0, 32'h00000002, 4'b0001};
    vecs[14] = '{0, 0, 8'h00, 1, 0, 0, 32'h0,        4'b0000, 1, 0, 32'h00000002, 4'b0001};
    vecs[15] = '{0, 0, 8'h00, 0, 1, 0, 32'h0,        4'b0000, 0, 1, 32'h00000000, 4'b0000};

    rst_n = 1'b0;
    drive(0, 0, 8'h00, 0, 0);
    #2;
    chk_out("reset", 0, 1, 32'h0, 4'b0000);
    #10;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].vld, vecs[i].addr, vecs[i].dat, vecs[i].flush, vecs[i].rdy);
      if (vecs[i].push) sb_q.push_back('{d: vecs[i].pdat, m: vecs[i].pmask});
      @(posedge clk);
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].evld, vecs[i].erdy, vecs[i].edat, vecs[i].emask);
    end

    // Backpressure: full word held while a write waits at the input.
    cyc(1, 0, 8'hA0, 0, 0);
    cyc(1, 1, 8'hA1, 0, 0);
    cyc(1, 2, 8'hA2, 0, 0);
    sb_q.push_back('{d: 32'hA3A2A1A0, m: 4'b1111});
    cyc(1, 3, 8'hA3, 0, 0);
    chk_out("bp_full", 1, 0, 32'hA3A2A1A0, 4'b1111);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 8'h77, 0, 0);
      chk_out($sformatf("bp_hold%0d", i), 1, 0, 32'hA3A2A1A0, 4'b1111);
    end
    cyc(1, 0, 8'h77, 0, 1);
    chk_out("bp_taken", 0, 1, 32'h0, 4'b0000);
    cyc(1, 0, 8'h77, 0, 1);
    chk_out("bp_held_write", 0, 1, 32'h00000077, 4'b0001);
    sb_q.push_back('{d: 32'h00000077, m: 4'b0001});
    cyc(0, 0, 8'h00, 1, 1);
    chk_out("bp_flush", 1, 0, 32'h00000077, 4'b0001);
    cyc(0, 0, 8'h00, 0, 1);
    chk_out("bp_drain", 0, 1, 32'h0, 4'b0000);

    // Async reset while a word is pending: discarded with no handshake.
    cyc(1, 3, 8'h99, 1, 0);
    chk_out("rst_emit", 1, 0, 32'h99000000, 4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst_async", 0, 1, 32'h0, 4'b0000);
    #1;
    rst_n = 1'b1;
    cyc(1, 2, 8'h5A, 0, 1);
    chk_out("rst_first_write", 0, 1, 32'h005A0000, 4'b0100);
    cyc(0, 0, 8'h00, 0, 1);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
